palette_lut: RTL
================

PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL provide the following parameters, one per line:
  INDEX_W  8  palette index width; the palette depth is 2**INDEX_W entries.
  CHAN_W   4  bit width of each colour channel.
  BANKS    2  number of independent palettes, at least 1.
REQ-002 SHALL have the following ports (BW = clog2(BANKS), minimum 1):
  clk            in   1            single clock; all logic on rising edge
  rst            in   1            synchronous, active-high reset
  pix_valid      in   1            pix_index is a live pixel this cycle
  pix_index      in   INDEX_W      colour index to look up
  bank_sel       in   BW           palette bank for pix_index
  pix_out_valid  out  1            pix_r/g/b carry a looked-up colour
  pix_r          out  CHAN_W       red channel
  pix_g          out  CHAN_W       green channel
  pix_b          out  CHAN_W       blue channel
  wr_en          in   1            palette write request
  wr_bank        in   BW           bank to write
  wr_index       in   INDEX_W      entry to write
  wr_data        in   3*CHAN_W     packed {r,g,b}
  wr_ready       out  1            write port accepts requests
  init_busy      out  1            default-palette load in progress

Function
REQ-003 SHALL store BANKS x 2**INDEX_W entries of 3*CHAN_W bits each.
REQ-004 SHALL implement a two-state FSM, INIT and RUN:
  - rst forces INIT.
  - INIT moves to RUN on the cycle after its counter writes the final entry.
  - RUN is left only by rst.
REQ-005 SHALL, in INIT, write one entry per cycle using a counter {bank, index} that runs from 0 to BANKS*2**INDEX_W-1.
REQ-006 SHALL load a grey ramp as the default palette: r = g = b = index[INDEX_W-1 -: CHAN_W]. If CHAN_W > INDEX_W, SHALL left-justify the index and zero-fill the low bits.
REQ-007 SHALL drive init_busy=1 and wr_ready=0 throughout INIT, and init_busy=0 and wr_ready=1 in RUN.
REQ-008 SHALL perform a write in RUN when wr_en=1: mem[wr_bank][wr_index] <= wr_data at that clock edge.
REQ-009 SHALL silently drop wr_en while wr_ready=0, with no buffering.
REQ-010 SHALL ignore a wr_bank value of BANKS or greater.
REQ-011 SHALL apply a lookup latency of exactly 2 cycles:
  - {pix_valid, pix_index, bank_sel} sampled at edge N appear on pix_out_valid/pix_r/g/b after edge N+2.
  - The pipeline is fully pipelined, accepting one pixel per cycle with no stalls.
REQ-012 SHALL drive pix_r/g/b to 0 whenever pix_out_valid=0, to provide blanking.
REQ-013 SHALL force pix_out_valid to 0 during INIT regardless of pix_valid, and for the 2 cycles after entry to RUN while the pipeline fills.
REQ-014 SHALL resolve a write and a lookup to the same bank and index in the same cycle as read-first: the lookup returns the old entry, and a lookup one cycle later returns the new entry.
REQ-015 SHALL return entry 0 of bank 0 for a bank_sel value of BANKS or greater.
REQ-016 SHALL be synthesisable as block RAM: one write port (shared by INIT and the host) and one registered read port.

Reset
REQ-017 SHALL, on rst=1 at any clock edge:
  - clear the pipeline: pix_out_valid=0, pix_r/g/b=0;
  - set init_busy=1, wr_ready=0, init counter=0;
  - enter INIT.
REQ-018 SHALL treat rst asserted mid-INIT or mid-RUN identically to power-on: the whole palette is reloaded with defaults and host writes are lost.
REQ-019 SHALL hold all outputs at their reset values while rst stays high.

Verification (defaults INDEX_W=8, CHAN_W=4, BANKS=2)
REQ-020 Reset, then idle: init_busy=1 for exactly 512 cycles after rst falls, then init_busy=0 and wr_ready=1, with pix_out_valid=0 throughout.
REQ-021 After init, pix_index=0xA5, bank_sel=0, pix_valid=1 for one cycle: pix_out_valid=1 with r=g=b=0xA exactly 2 cycles later, and 0 before and after.
REQ-022 Write bank1[0x10]=0xF0F; look up bank0 0x10 and bank1 0x10 on consecutive cycles: outputs 0x111 then {r=F,g=0,b=F}; bank0 is unchanged.
REQ-023 Same-cycle write 0x123 and lookup at bank0[0x20]: returns 0x222 (old value); the next-cycle lookup returns 0x123.
REQ-024 wr_en=1 during INIT with data 0xFFF at bank0[0x00]: after init, a lookup of 0x00 returns 0x000.
REQ-025 Stream of 256 consecutive indices 0..255 with pix_valid=1, then rst asserted at pixel 100: outputs are back-to-back correct values up to the reset, then pix_out_valid=0 and init_busy=1 on the next cycle, and the full 512-cycle reload follows.

Source files
------------

// File: rtl/palette_lut.sv
// palette_lut: banked colour palette lookup with a default grey-ramp load.
//
// The palette has BANKS banks. Each bank holds 2**INDEX_W entries, and each
// entry is a packed {r,g,b} value of 3*CHAN_W bits.
//
// After reset the block walks every {bank, index} address, one entry per
// cycle, and writes a grey ramp. It then opens the host write port and
// starts accepting pixel lookups. A lookup sampled at edge N appears on the
// outputs after edge N+2. The output colour is forced to zero whenever
// pix_out_valid is low.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   pix_valid/index/bank_sel   pixel lookup request
//   pix_out_valid, pix_r/g/b   looked-up colour, blanked when not valid
//   wr_en/bank/index/data      host palette write, packed {r,g,b}
//   wr_ready                   host writes are accepted (RUN)
//   init_busy                  default palette load in progress (INIT)
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | walk all entries writing the grey ramp; host writes and pixels
//       | are ignored
// RUN   | host writes accepted, lookups flow through the 2-cycle pipe
module palette_lut #(
  parameter int INDEX_W = 8,
  parameter int CHAN_W  = 4,
  parameter int BANKS   = 2,
  localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [INDEX_W-1:0]    pix_index,
  input  logic [BW-1:0]         bank_sel,
  output logic                  pix_out_valid,
  output logic [CHAN_W-1:0]     pix_r,
  output logic [CHAN_W-1:0]     pix_g,
  output logic [CHAN_W-1:0]     pix_b,
  input  logic                  wr_en,
  input  logic [BW-1:0]         wr_bank,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [3*CHAN_W-1:0]   wr_data,
  output logic                  wr_ready,
  output logic                  init_busy
);

  localparam int DEPTH   = 2**INDEX_W;
  localparam int AW      = BW + INDEX_W;
  localparam int ENTRIES = BANKS * DEPTH;
  localparam int DW      = 3 * CHAN_W;

  localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);
  localparam logic [BW:0]   NUM_BANKS = (BW+1)'(BANKS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic              in_init;
  logic [AW-1:0]     init_cnt;
  logic [CHAN_W-1:0] grey;

  logic [DW-1:0]     mem [ENTRIES];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic [AW-1:0]     mem_raddr;
  logic [DW-1:0]     rd_data;

  logic              rd_valid;
  logic              dly_valid;
  logic [DW-1:0]     dly_data;

  assign in_init   = (state == ST_INIT);
  assign init_busy = in_init;
  assign wr_ready  = ~in_init;

  // FSM and init address counter. The counter's low bits are the index and
  // its high bits are the bank, so it sweeps bank 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (in_init) begin
      if (init_cnt == LAST_ADDR) begin
        state <= ST_RUN;
      end else begin
        init_cnt <= init_cnt + AW'(1);
      end
    end
  end

  // Grey level is the top CHAN_W bits of the index. A narrow index is
  // left-justified and zero-filled at the bottom.
  generate
    if (CHAN_W <= INDEX_W) begin : g_grey_msb
      assign grey = init_cnt[INDEX_W-1 -: CHAN_W];
    end else begin : g_grey_pad
      assign grey = {init_cnt[INDEX_W-1:0], {(CHAN_W-INDEX_W){1'b0}}};
    end
  endgenerate

  // The single write port is shared between the init sweep and the host.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_cnt;
    mem_wdata = {grey, grey, grey};
    if (in_init) begin
      mem_we = ~rst;
    end else begin
      mem_we    = ~rst & wr_en & ({1'b0, wr_bank} < NUM_BANKS);
      mem_waddr = {wr_bank, wr_index};
      mem_wdata = wr_data;
    end
  end

  // An out-of-range bank falls back to bank 0, entry 0.
  assign mem_raddr = ({1'b0, bank_sel} < NUM_BANKS) ? {bank_sel, pix_index} : '0;

  // Block RAM with a registered read port. The read samples the array in
  // the same edge as the write, so a colliding lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data <= mem[mem_raddr];
  end

  // The valid flag travels alongside the RAM read, then through one delay
  // stage and the blanking output register. Pixels presented during INIT
  // never enter the pipe, which also gives the fill gap after entering RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid      <= 1'b0;
      dly_valid     <= 1'b0;
      dly_data      <= '0;
      pix_out_valid <= 1'b0;
      pix_r         <= '0;
      pix_g         <= '0;
      pix_b         <= '0;
    end else begin
      rd_valid      <= pix_valid & ~in_init;
      dly_valid     <= rd_valid;
      dly_data      <= rd_data;
      pix_out_valid <= dly_valid;
      if (dly_valid) begin
        {pix_r, pix_g, pix_b} <= dly_data;
      end else begin
        {pix_r, pix_g, pix_b} <= '0;
      end
    end
  end

endmodule
